// File: rtl/sort_stream_checker_pkg.sv
// sort_pkg: shared widths, FSM state encoding and the packet report record
// used by the sort stream checker.
//   LEN_W   - width of a packet length (holds 0..MAX_PKT_LEN)
//   SUM_W   - width of the wrapping packet checksum
//   state_t - IDLE between packets, IN_PKT while a packet is open
//   report_t- one packet report (length, flags, checksum)
// The report record is sized from the package defaults, so any change to
// the data width or maximum packet length is made here and the top module
// picks it up through its parameter defaults.
package sort_pkg;

    localparam int DWIDTH_DEF      = 32;
    localparam int MAX_PKT_LEN_DEF = 32;
    localparam int CNT_WIDTH_DEF   = 16;

    localparam int LEN_W = $clog2(MAX_PKT_LEN_DEF) + 1;
    localparam int SUM_W = DWIDTH_DEF + $clog2(MAX_PKT_LEN_DEF);

    typedef enum logic {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } state_t;

    typedef struct packed {
        logic [LEN_W-1:0] len;
        logic             sorted;
        logic             frame_err;
        logic             len_err;
        logic [SUM_W-1:0] sum;
    } report_t;

    function automatic logic rpt_has_err(report_t r);
        return r.frame_err | r.len_err;
    endfunction

endpackage

// File: rtl/sort_stream_checker_sat_counter.sv
// sat_counter: counter that increments on inc and sticks at all-ones.
//   clk_i   - clock
//   arst_i  - asynchronous active-high reset (clears count)
//   inc     - increment request for this cycle
//   count   - current count
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             arst_i,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            count <= '0;
        end else if (inc && !(&count)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/sort_stream_checker.sv
// sort_stream_checker: Avalon-ST sink that consumes the sorter output and
// reports, per packet, its length, whether it is non-decreasing (unsigned),
// framing / length errors and a wrapping additive checksum.
//   clk_i, arst_i        - clock, asynchronous active-high reset
//   snk_*                - Avalon-ST sink (data, SOP, EOP, valid, ready)
//   stall_i              - forces snk_ready_o low to inject backpressure
//   res_valid_o          - one-cycle pulse, res_* carry a new report
//   res_len_o .. sum_o   - report fields, held until the next report
//   pkt_cnt_o, err_cnt_o - saturating report / error counters
module sort_stream_checker
    import sort_pkg::*;
#(
    parameter int DWIDTH      = DWIDTH_DEF,
    parameter int MAX_PKT_LEN = MAX_PKT_LEN_DEF,
    parameter int CNT_WIDTH   = CNT_WIDTH_DEF
) (
    input  logic                                  clk_i,
    input  logic                                  arst_i,
    input  logic [DWIDTH-1:0]                     snk_data_i,
    input  logic                                  snk_startofpacket_i,
    input  logic                                  snk_endofpacket_i,
    input  logic                                  snk_valid_i,
    output logic                                  snk_ready_o,
    input  logic                                  stall_i,
    output logic                                  res_valid_o,
    output logic [$clog2(MAX_PKT_LEN):0]          res_len_o,
    output logic                                  res_sorted_o,
    output logic                                  res_frame_err_o,
    output logic                                  res_len_err_o,
    output logic [DWIDTH+$clog2(MAX_PKT_LEN)-1:0] res_sum_o,
    output logic [CNT_WIDTH-1:0]                  pkt_cnt_o,
    output logic [CNT_WIDTH-1:0]                  err_cnt_o
);

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_PKT_LEN);

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [SUM_W-1:0]  sum_q, sum_d;
    logic [DWIDTH-1:0] prev_q, prev_d;
    logic              sorted_q, sorted_d;
    logic              len_err_q, len_err_d;

    report_t res_q, pend_q, pend_d;
    logic    res_vld_q, pend_vld_q, pend_vld_d;

    report_t prim, sec, out, one_beat;
    logic    prim_vld, sec_vld, out_vld, orphan, accept;

    assign snk_ready_o = ~stall_i & ~arst_i;
    assign accept      = snk_valid_i & snk_ready_o;

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        sum_d     = sum_q;
        prev_d    = prev_q;
        sorted_d  = sorted_q;
        len_err_d = len_err_q;
        prim_vld  = 1'b0;
        prim      = '0;
        sec_vld   = 1'b0;
        sec       = '0;
        orphan    = 1'b0;
        one_beat  = '{len: LEN_W'(1), sorted: 1'b1, frame_err: 1'b0,
                      len_err: 1'b0, sum: SUM_W'(snk_data_i)};

        if (accept) begin
            if (snk_startofpacket_i) begin
                // Any SOP closes an open packet as a framing error and
                // restarts accumulation with this beat.
                if (state_q == IN_PKT) begin
                    prim_vld = 1'b1;
                    prim     = '{len: len_q, sorted: sorted_q, frame_err: 1'b1,
                                 len_err: len_err_q, sum: sum_q};
                end
                len_d     = LEN_W'(1);
                sum_d     = SUM_W'(snk_data_i);
                prev_d    = snk_data_i;
                sorted_d  = 1'b1;
                len_err_d = 1'b0;
                if (snk_endofpacket_i) begin
                    state_d = IDLE;
                    if (state_q == IN_PKT) begin
                        sec_vld = 1'b1;
                        sec     = one_beat;
                    end else begin
                        prim_vld = 1'b1;
                        prim     = one_beat;
                    end
                end else begin
                    state_d = IN_PKT;
                end
            end else if (state_q == IDLE) begin
                orphan = 1'b1;
            end else begin
                len_d     = (len_q == MAX_LEN) ? MAX_LEN : len_q + 1'b1;
                len_err_d = len_err_q | (len_q == MAX_LEN);
                sum_d     = sum_q + SUM_W'(snk_data_i);
                sorted_d  = sorted_q & (snk_data_i >= prev_q);
                prev_d    = snk_data_i;
                if (snk_endofpacket_i) begin
                    state_d  = IDLE;
                    prim_vld = 1'b1;
                    prim     = '{len: len_d, sorted: sorted_d, frame_err: 1'b0,
                                 len_err: len_err_d, sum: sum_d};
                end
            end
        end

        // A pending report always goes out first. While it is pending the
        // FSM is in IDLE, so at most one new report can arrive and it takes
        // the pending slot in turn.
        out_vld    = pend_vld_q | prim_vld;
        out        = pend_vld_q ? pend_q : prim;
        pend_vld_d = pend_vld_q ? prim_vld : sec_vld;
        pend_d     = pend_vld_q ? prim : sec;
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q    <= IDLE;
            len_q      <= '0;
            sum_q      <= '0;
            prev_q     <= '0;
            sorted_q   <= 1'b0;
            len_err_q  <= 1'b0;
            res_q      <= '0;
            res_vld_q  <= 1'b0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            sum_q      <= sum_d;
            prev_q     <= prev_d;
            sorted_q   <= sorted_d;
            len_err_q  <= len_err_d;
            res_vld_q  <= out_vld;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            if (out_vld) begin
                res_q <= out;
            end
        end
    end

    sat_counter #(.WIDTH(CNT_WIDTH)) u_pkt_cnt (
        .clk_i  (clk_i),
        .arst_i (arst_i),
        .inc    (out_vld),
        .count  (pkt_cnt_o)
    );

    // Pending reports are always clean single-beat packets, so an orphan and
    // an erroneous report never need counting in the same cycle.
    sat_counter #(.WIDTH(CNT_WIDTH)) u_err_cnt (
        .clk_i  (clk_i),
        .arst_i (arst_i),
        .inc    (orphan | (out_vld & rpt_has_err(out))),
        .count  (err_cnt_o)
    );

    assign res_valid_o     = res_vld_q;
    assign res_len_o       = res_q.len;
    assign res_sorted_o    = res_q.sorted;
    assign res_frame_err_o = res_q.frame_err;
    assign res_len_err_o   = res_q.len_err;
    assign res_sum_o       = res_q.sum;

endmodule

// File: tb/tb_sort_stream_checker.sv
module tb_sort_stream_checker;

    logic        clk_i = 1'b0;
    logic        arst_i = 1'b1;
    logic [31:0] snk_data_i = '0;
    logic        snk_startofpacket_i = 1'b0;
    logic        snk_endofpacket_i = 1'b0;
    logic        snk_valid_i = 1'b0;
    logic        snk_ready_o;
    logic        stall_i = 1'b0;
    logic        res_valid_o;
    logic [5:0]  res_len_o;
    logic        res_sorted_o;
    logic        res_frame_err_o;
    logic        res_len_err_o;
    logic [36:0] res_sum_o;
    logic [15:0] pkt_cnt_o;
    logic [15:0] err_cnt_o;

    sort_stream_checker dut (
        .clk_i               (clk_i),
        .arst_i              (arst_i),
        .snk_data_i          (snk_data_i),
        .snk_startofpacket_i (snk_startofpacket_i),
        .snk_endofpacket_i   (snk_endofpacket_i),
        .snk_valid_i         (snk_valid_i),
        .snk_ready_o         (snk_ready_o),
        .stall_i             (stall_i),
        .res_valid_o         (res_valid_o),
        .res_len_o           (res_len_o),
        .res_sorted_o        (res_sorted_o),
        .res_frame_err_o     (res_frame_err_o),
        .res_len_err_o       (res_len_err_o),
        .res_sum_o           (res_sum_o),
        .pkt_cnt_o           (pkt_cnt_o),
        .err_cnt_o           (err_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [5:0]  len;
        logic        sorted;
        logic        fe;
        logic        le;
        logic [36:0] sum;
        int          cyc;
    } rep_t;

    typedef struct {
        int          n;
        logic [31:0] d [0:5];
        int          stall_at;
        logic [5:0]  len;
        logic        sorted;
        logic [36:0] sum;
    } vec_t;

    rep_t rq[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Report monitor, sampled on the falling edge.
    always @(negedge clk_i) begin
        if (res_valid_o)
            rq.push_back('{res_len_o, res_sorted_o, res_frame_err_o,
                           res_len_err_o, res_sum_o, cyc});
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Present one beat from posedge+1; it is accepted at the next edge.
    task automatic beat(input logic [31:0] d, input logic s, input logic e);
        snk_data_i = d;
        snk_startofpacket_i = s;
        snk_endofpacket_i = e;
        snk_valid_i = 1'b1;
        @(posedge clk_i);
        #1;
        snk_valid_i = 1'b0;
        snk_startofpacket_i = 1'b0;
        snk_endofpacket_i = 1'b0;
    endtask

    task automatic wait_reports(input int n);
        int t = 0;
        while (rq.size() < n && t < 100) begin
            @(posedge clk_i);
            #1;
            t++;
        end
        @(posedge clk_i);
        #1;
        chk("report count", rq.size(), n);
    endtask

    task automatic pop_chk(input string nm, input logic [5:0] len, input logic sorted,
                           input logic fe, input logic le, input logic [36:0] sum,
                           output int c);
        rep_t r;
        c = -1;
        if (rq.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: report missing", nm);
        end else begin
            r = rq.pop_front();
            c = r.cyc;
            chk({nm, " len"}, r.len, len);
            chk({nm, " sorted"}, r.sorted, sorted);
            chk({nm, " frame_err"}, r.fe, fe);
            chk({nm, " len_err"}, r.le, le);
            chk({nm, " sum"}, r.sum, sum);
        end
    endtask

    vec_t tbl [0:6];
    int   c0, c1, c2;

    initial begin
        tbl[0] = '{4, '{32'd3, 32'd5, 32'd5, 32'd9, 32'd0, 32'd0}, -1, 6'd4, 1'b1, 37'd22};
        tbl[1] = '{3, '{32'd7, 32'd2, 32'd8, 32'd0, 32'd0, 32'd0}, 2, 6'd3, 1'b0, 37'd17};
        tbl[2] = '{1, '{32'hFFFFFFFF, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0}, -1, 6'd1, 1'b1, 37'hFFFFFFFF};
        tbl[3] = '{2, '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0}, -1, 6'd2, 1'b1, 37'd0};
        tbl[4] = '{2, '{32'd10, 32'd9, 32'd0, 32'd0, 32'd0, 32'd0}, -1, 6'd2, 1'b0, 37'd19};
        tbl[5] = '{2, '{32'h80000000, 32'h7FFFFFFF, 32'd0, 32'd0, 32'd0, 32'd0}, -1, 6'd2, 1'b0, 37'hFFFFFFFF};
        tbl[6] = '{3, '{32'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0, 32'd0}, 1, 6'd3, 1'b1, 37'h1FFFFFFFF};

        // Reset state
        #12;
        chk("reset ready", snk_ready_o, 0);
        chk("reset res_valid", res_valid_o, 0);
        chk("reset res_len", res_len_o, 0);
        chk("reset res_sum", res_sum_o, 0);
        chk("reset pkt_cnt", pkt_cnt_o, 0);
        chk("reset err_cnt", err_cnt_o, 0);
        #10;
        arst_i = 1'b0;
        #1;
        chk("ready after reset", snk_ready_o, 1);
        stall_i = 1'b1;
        #1;
        chk("ready under stall", snk_ready_o, 0);
        stall_i = 1'b0;
        @(posedge clk_i);
        #1;

        // First packet: exact report timing and hold
        beat(3, 1, 0);
        beat(5, 0, 0);
        beat(5, 0, 0);
        chk("no early report", res_valid_o, 0);
        beat(9, 0, 1);
        chk("t1 valid after eop", res_valid_o, 1);
        chk("t1 len", res_len_o, 4);
        chk("t1 sorted", res_sorted_o, 1);
        chk("t1 sum", res_sum_o, 22);
        chk("t1 errs", {res_frame_err_o, res_len_err_o}, 0);
        chk("t1 pkt_cnt", pkt_cnt_o, 1);
        chk("t1 err_cnt", err_cnt_o, 0);
        @(posedge clk_i);
        #1;
        chk("t1 pulse width", res_valid_o, 0);
        chk("t1 len held", res_len_o, 4);
        rq.delete();

        // Table of well-formed packets, sent back to back
        for (int i = 0; i < 7; i++) begin
            for (int b = 0; b < tbl[i].n; b++) begin
                if (b == tbl[i].stall_at) begin
                    stall_i = 1'b1;
                    snk_data_i = tbl[i].d[b];
                    snk_startofpacket_i = 1'b0;
                    snk_endofpacket_i = (b == tbl[i].n - 1);
                    snk_valid_i = 1'b1;
                    for (int s = 0; s < 3; s++) begin
                        @(posedge clk_i);
                        #1;
                        chk("stalled ready", snk_ready_o, 0);
                    end
                    stall_i = 1'b0;
                end
                beat(tbl[i].d[b], b == 0, b == tbl[i].n - 1);
            end
        end
        wait_reports(7);
        for (int i = 0; i < 7; i++)
            pop_chk($sformatf("vec%0d", i), tbl[i].len, tbl[i].sorted, 1'b0, 1'b0, tbl[i].sum, c0);
        chk("table pkt_cnt", pkt_cnt_o, 8);
        chk("table err_cnt", err_cnt_o, 0);

        // SOP before EOP splits the packet
        beat(1, 1, 0);
        beat(2, 0, 0);
        beat(4, 1, 0);
        beat(6, 0, 1);
        wait_reports(2);
        pop_chk("frame open", 6'd2, 1'b1, 1'b1, 1'b0, 37'd3, c0);
        pop_chk("frame next", 6'd2, 1'b1, 1'b0, 1'b0, 37'd10, c0);
        chk("frame err_cnt", err_cnt_o, 1);

        // SOP+EOP mid-packet, then another single beat: pending chain
        beat(5, 1, 0);
        beat(7, 0, 0);
        beat(9, 1, 1);
        beat(3, 1, 1);
        wait_reports(3);
        pop_chk("split open", 6'd2, 1'b1, 1'b1, 1'b0, 37'd12, c0);
        pop_chk("split single", 6'd1, 1'b1, 1'b0, 1'b0, 37'd9, c1);
        pop_chk("chained single", 6'd1, 1'b1, 1'b0, 1'b0, 37'd3, c2);
        chk("pending consecutive", c1 - c0, 1);
        chk("chain consecutive", c2 - c1, 1);
        chk("split pkt_cnt", pkt_cnt_o, 13);
        chk("split err_cnt", err_cnt_o, 2);

        // Overlong packet: 34 ascending beats
        for (int i = 0; i < 34; i++)
            beat(i, i == 0, i == 33);
        wait_reports(1);
        pop_chk("overlong", 6'd32, 1'b1, 1'b0, 1'b1, 37'd561, c0);
        chk("overlong err_cnt", err_cnt_o, 3);

        // Orphan beat in IDLE
        beat(42, 0, 0);
        repeat (3) @(posedge clk_i);
        #1;
        chk("orphan no report", rq.size(), 0);
        chk("orphan err_cnt", err_cnt_o, 4);
        chk("orphan pkt_cnt", pkt_cnt_o, 14);

        // Reset mid-packet
        beat(1, 1, 0);
        beat(2, 0, 0);
        #2;
        arst_i = 1'b1;
        #1;
        chk("midrst ready", snk_ready_o, 0);
        chk("midrst pkt_cnt", pkt_cnt_o, 0);
        chk("midrst err_cnt", err_cnt_o, 0);
        chk("midrst res_len", res_len_o, 0);
        chk("midrst res_sum", res_sum_o, 0);
        #3;
        arst_i = 1'b0;
        @(posedge clk_i);
        #1;
        rq.delete();
        beat(4, 1, 0);
        beat(8, 0, 1);
        chk("post-rst valid", res_valid_o, 1);
        chk("post-rst len", res_len_o, 2);
        chk("post-rst sum", res_sum_o, 12);
        chk("post-rst errs", {res_frame_err_o, res_len_err_o}, 0);
        chk("post-rst pkt_cnt", pkt_cnt_o, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
